// File: rtl/snoop_bus_controller_pkg.sv
// Shared MSI coherence definitions: line states, bus message codes and the
// snoop FSM state type used by the bus-side controller.
package msi_pkg;

   localparam logic [1:0] INVALID    = 2'b00;
   localparam logic [1:0] EXCLUSIVE  = 2'b01;
   localparam logic [1:0] SHARED     = 2'b10;

   localparam logic [1:0] READ_MISS  = 2'b00;
   localparam logic [1:0] WRITE_MISS = 2'b01;
   localparam logic [1:0] INVALIDATE = 2'b10;
   localparam logic [1:0] EMPTY      = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'b00,
      ST_LOOKUP    = 2'b01,
      ST_WRITEBACK = 2'b10,
      ST_DONE      = 2'b11
   } snoop_state_e;

   // 2'b11 is not a legal line state and is treated as not holding the block
   function automatic logic line_is_valid(input logic [1:0] st);
      return (st == EXCLUSIVE) || (st == SHARED);
   endfunction

endpackage

// File: rtl/snoop_bus_controller_if.sv
// Bus, CPU-update, CPU-read and write-back signals of the snoop controller.
// slave = controller side, master = bus/CPU/memory side.
interface snoop_bus_controller_if #(
   parameter int ADDR_W = 8,
   parameter int IDX_W  = 2
);
   logic                      bus_valid;
   logic [1:0]                bus_msg;
   logic [ADDR_W-1:0]         bus_addr;
   logic                      bus_ready;
   logic                      cpu_upd_valid;
   logic [IDX_W-1:0]          cpu_upd_index;
   logic [ADDR_W-IDX_W-1:0]   cpu_upd_tag;
   logic [1:0]                cpu_upd_state;
   logic                      cpu_upd_ready;
   logic [IDX_W-1:0]          cpu_rd_index;
   logic [1:0]                cpu_rd_state;
   logic [ADDR_W-IDX_W-1:0]   cpu_rd_tag;
   logic                      wb_valid;
   logic [ADDR_W-1:0]         wb_addr;
   logic                      wb_ready;
   logic                      abort_mem;
   logic                      snoop_done;
   logic                      proto_err;

   modport slave (
      input  bus_valid, bus_msg, bus_addr,
      output bus_ready,
      input  cpu_upd_valid, cpu_upd_index, cpu_upd_tag, cpu_upd_state,
      output cpu_upd_ready,
      input  cpu_rd_index,
      output cpu_rd_state, cpu_rd_tag,
      output wb_valid, wb_addr,
      input  wb_ready,
      output abort_mem, snoop_done, proto_err
   );

   modport master (
      output bus_valid, bus_msg, bus_addr,
      input  bus_ready,
      output cpu_upd_valid, cpu_upd_index, cpu_upd_tag, cpu_upd_state,
      input  cpu_upd_ready,
      output cpu_rd_index,
      input  cpu_rd_state, cpu_rd_tag,
      input  wb_valid, wb_addr,
      output wb_ready,
      input  abort_mem, snoop_done, proto_err
   );
endinterface

// File: rtl/snoop_bus_controller_array.sv
// Direct-mapped tag/state storage: combinational CPU read port, combinational
// lookup port for the snoop FSM, and a single write port.
module snoop_line_array
   import msi_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int IDX_W  = 2
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [IDX_W-1:0]        rd_index_i,
   output logic [1:0]              rd_state_o,
   output logic [ADDR_W-IDX_W-1:0] rd_tag_o,
   input  logic [IDX_W-1:0]        lk_index_i,
   output logic [1:0]              lk_state_o,
   output logic [ADDR_W-IDX_W-1:0] lk_tag_o,
   input  logic                    wr_en_i,
   input  logic [IDX_W-1:0]        wr_index_i,
   input  logic [1:0]              wr_state_i,
   input  logic [ADDR_W-IDX_W-1:0] wr_tag_i
);
   localparam int LINES = 1 << IDX_W;

   logic [1:0]              state_q [LINES];
   logic [ADDR_W-IDX_W-1:0] tag_q   [LINES];

   // Line storage: cleared on reset, single write per cycle otherwise
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < LINES; i++) begin
            state_q[i] <= INVALID;
            tag_q[i]   <= '0;
         end
      end else if (wr_en_i) begin
         state_q[wr_index_i] <= wr_state_i;
         tag_q[wr_index_i]   <= wr_tag_i;
      end
   end

   assign rd_state_o = state_q[rd_index_i];
   assign rd_tag_o   = tag_q[rd_index_i];
   assign lk_state_o = state_q[lk_index_i];
   assign lk_tag_o   = tag_q[lk_index_i];

endmodule

// File: rtl/snoop_bus_controller.sv
// Bus-side MSI snoop controller: looks up remote misses/invalidates, downgrades
// or invalidates the line, and writes back + aborts memory for exclusive hits.
module snoop_bus_controller
   import msi_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int IDX_W  = 2
) (
   input  logic             clock,
   input  logic             reset,
   snoop_bus_controller_if.slave bus
);
   localparam int TAG_W = ADDR_W - IDX_W;

   snoop_state_e      state_q, state_d;
   logic [1:0]        msg_q, msg_d;
   logic [ADDR_W-1:0] addr_q, addr_d;

   logic [IDX_W-1:0]  lk_idx_s;
   logic [TAG_W-1:0]  lk_tag_s;
   logic [1:0]        line_state_s;
   logic [TAG_W-1:0]  line_tag_s;
   logic              hit_s;
   logic              excl_hit_s;

   logic              commit_en_s;
   logic [1:0]        commit_state_s;
   logic              abort_s;
   logic              perr_s;

   logic              bus_ready_s;
   logic              upd_ready_s;
   logic              upd_fire_s;
   logic              wr_en_s;
   logic [IDX_W-1:0]  wr_index_s;
   logic [1:0]        wr_state_s;
   logic [TAG_W-1:0]  wr_tag_s;

   assign lk_idx_s   = addr_q[IDX_W-1:0];
   assign lk_tag_s   = addr_q[ADDR_W-1:IDX_W];
   assign hit_s      = line_is_valid(line_state_s) && (line_tag_s == lk_tag_s);
   assign excl_hit_s = hit_s && (line_state_s == EXCLUSIVE);

   // Control state and captured bus message
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
         msg_q   <= EMPTY;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         msg_q   <= msg_d;
         addr_q  <= addr_d;
      end
   end

   // Next-state, lookup decision and line commit
   always_comb begin
      state_d        = state_q;
      msg_d          = msg_q;
      addr_d         = addr_q;
      commit_en_s    = 1'b0;
      commit_state_s = line_state_s;
      abort_s        = 1'b0;
      perr_s         = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.bus_valid) begin
               msg_d   = bus.bus_msg;
               addr_d  = bus.bus_addr;
               state_d = ST_LOOKUP;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_LOOKUP: begin
            state_d = ST_DONE;
            case (msg_q)
               READ_MISS: begin
                  if (excl_hit_s) begin
                     commit_en_s    = 1'b1;
                     commit_state_s = SHARED;
                     abort_s        = 1'b1;
                     state_d        = ST_WRITEBACK;
                  end else begin
                     state_d = ST_DONE;
                  end
               end
               WRITE_MISS: begin
                  if (hit_s) begin
                     commit_en_s    = 1'b1;
                     commit_state_s = INVALID;
                     abort_s        = excl_hit_s;
                     state_d        = excl_hit_s ? ST_WRITEBACK : ST_DONE;
                  end else begin
                     state_d = ST_DONE;
                  end
               end
               INVALIDATE: begin
                  // an invalidate should never find a sole owner: flag, drop, no data
                  if (hit_s) begin
                     commit_en_s    = 1'b1;
                     commit_state_s = INVALID;
                     perr_s         = excl_hit_s;
                  end else begin
                     commit_en_s = 1'b0;
                  end
               end
               default: state_d = ST_DONE;
            endcase
         end
         ST_WRITEBACK: begin
            if (bus.wb_ready) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_WRITEBACK;
            end
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   assign bus_ready_s = (state_q == ST_IDLE) && !reset;
   assign upd_ready_s = (state_q != ST_LOOKUP) && !reset;
   assign upd_fire_s  = bus.cpu_upd_valid && upd_ready_s && (bus.cpu_upd_state != 2'b11);

   // Commit and CPU update are exclusive in time because LOOKUP blocks the CPU
   assign wr_en_s    = commit_en_s || upd_fire_s;
   assign wr_index_s = commit_en_s ? lk_idx_s       : bus.cpu_upd_index;
   assign wr_state_s = commit_en_s ? commit_state_s : bus.cpu_upd_state;
   assign wr_tag_s   = commit_en_s ? line_tag_s     : bus.cpu_upd_tag;

   snoop_line_array #(
      .ADDR_W (ADDR_W),
      .IDX_W  (IDX_W)
   ) u_array (
      .clock      (clock),
      .reset      (reset),
      .rd_index_i (bus.cpu_rd_index),
      .rd_state_o (bus.cpu_rd_state),
      .rd_tag_o   (bus.cpu_rd_tag),
      .lk_index_i (lk_idx_s),
      .lk_state_o (line_state_s),
      .lk_tag_o   (line_tag_s),
      .wr_en_i    (wr_en_s),
      .wr_index_i (wr_index_s),
      .wr_state_i (wr_state_s),
      .wr_tag_i   (wr_tag_s)
   );

   assign bus.bus_ready     = bus_ready_s;
   assign bus.cpu_upd_ready = upd_ready_s;
   assign bus.wb_valid      = (state_q == ST_WRITEBACK);
   assign bus.wb_addr       = addr_q;
   assign bus.abort_mem     = abort_s && !reset;
   assign bus.proto_err     = perr_s && !reset;
   assign bus.snoop_done    = (state_q == ST_DONE);

endmodule

// File: tb/tb_snoop_bus_controller.sv
// Directed self-checking bench for snoop_bus_controller; expected values are
// hand-derived from the MSI snoop rules for each message/line combination.
module tb_snoop_bus_controller;
   import msi_pkg::*;

   logic clock = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;
   logic [1:0] rs;
   logic [5:0] rt;

   always #5 clock = ~clock;

   snoop_bus_controller_if #(.ADDR_W(8), .IDX_W(2)) bif ();

   snoop_bus_controller #(.ADDR_W(8), .IDX_W(2)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bif)
   );

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic read_line(input logic [1:0] idx, output logic [1:0] st, output logic [5:0] tg);
      bif.cpu_rd_index = idx;
      #1;
      st = bif.cpu_rd_state;
      tg = bif.cpu_rd_tag;
   endtask

   task automatic cpu_write(input logic [1:0] idx, input logic [5:0] tg, input logic [1:0] st);
      bif.cpu_upd_valid = 1'b1;
      bif.cpu_upd_index = idx;
      bif.cpu_upd_tag   = tg;
      bif.cpu_upd_state = st;
      tick();
      bif.cpu_upd_valid = 1'b0;
   endtask

   // drives one message for the accept cycle; returns in the LOOKUP cycle
   task automatic send(input logic [1:0] msg, input logic [7:0] addr);
      bif.bus_valid = 1'b1;
      bif.bus_msg   = msg;
      bif.bus_addr  = addr;
      tick();
      bif.bus_valid = 1'b0;
      bif.bus_msg   = EMPTY;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      tick();
      tick();
      total++; if (bif.bus_ready !== 1'b0) begin bad++; $display("FAIL rst_bus_ready got=%0b exp=0", bif.bus_ready); end
      total++; if (bif.cpu_upd_ready !== 1'b0) begin bad++; $display("FAIL rst_upd_ready got=%0b exp=0", bif.cpu_upd_ready); end
      total++; if (bif.wb_valid !== 1'b0) begin bad++; $display("FAIL rst_wb_valid got=%0b exp=0", bif.wb_valid); end
      reset = 1'b0;
      #1;
      total++; if (bif.bus_ready !== 1'b1) begin bad++; $display("FAIL post_rst_bus_ready got=%0b exp=1", bif.bus_ready); end
      for (int i = 0; i < 4; i++) begin
         read_line(i[1:0], rs, rt);
         total++; if (rs !== 2'b00 || rt !== 6'h00) begin bad++; $display("FAIL rst_line%0d got=%0b/%h exp=00/00", i, rs, rt); end
      end
   endtask

   task automatic test_shared_read;
      cpu_write(2'd1, 6'h05, SHARED);
      total++; if (bif.bus_ready !== 1'b1) begin bad++; $display("FAIL sr_bus_ready got=%0b exp=1", bif.bus_ready); end
      send(READ_MISS, 8'h15);
      total++; if (bif.abort_mem !== 1'b0 || bif.snoop_done !== 1'b0) begin bad++; $display("FAIL sr_lookup abort=%0b done=%0b exp=0/0", bif.abort_mem, bif.snoop_done); end
      total++; if (bif.bus_ready !== 1'b0) begin bad++; $display("FAIL sr_busy_ready got=%0b exp=0", bif.bus_ready); end
      tick();
      total++; if (bif.snoop_done !== 1'b1 || bif.wb_valid !== 1'b0) begin bad++; $display("FAIL sr_done done=%0b wb=%0b exp=1/0", bif.snoop_done, bif.wb_valid); end
      read_line(2'd1, rs, rt);
      total++; if (rs !== SHARED || rt !== 6'h05) begin bad++; $display("FAIL sr_line got=%0b/%h exp=10/05", rs, rt); end
      tick();
      total++; if (bif.snoop_done !== 1'b0) begin bad++; $display("FAIL sr_done_pulse got=%0b exp=0", bif.snoop_done); end
   endtask

   task automatic test_excl_write_wb;
      cpu_write(2'd2, 6'h3A, EXCLUSIVE);
      bif.wb_ready = 1'b0;
      send(WRITE_MISS, 8'hEA);
      total++; if (bif.abort_mem !== 1'b1) begin bad++; $display("FAIL ew_abort got=%0b exp=1", bif.abort_mem); end
      tick();
      total++; if (bif.abort_mem !== 1'b0) begin bad++; $display("FAIL ew_abort_pulse got=%0b exp=0", bif.abort_mem); end
      read_line(2'd2, rs, rt);
      total++; if (rs !== INVALID) begin bad++; $display("FAIL ew_line got=%0b exp=00", rs); end
      for (int c = 0; c < 3; c++) begin
         total++; if (bif.wb_valid !== 1'b1 || bif.wb_addr !== 8'hEA || bif.snoop_done !== 1'b0) begin
            bad++; $display("FAIL ew_wb_hold%0d valid=%0b addr=%h done=%0b exp=1/ea/0", c, bif.wb_valid, bif.wb_addr, bif.snoop_done);
         end
         if (c < 2) tick();
      end
      bif.wb_ready = 1'b1;
      tick();
      bif.wb_ready = 1'b0;
      total++; if (bif.snoop_done !== 1'b1 || bif.wb_valid !== 1'b0) begin bad++; $display("FAIL ew_done done=%0b wb=%0b exp=1/0", bif.snoop_done, bif.wb_valid); end
      tick();
   endtask

   task automatic test_excl_read;
      cpu_write(2'd0, 6'h01, EXCLUSIVE);
      bif.wb_ready = 1'b1;
      send(READ_MISS, 8'h04);
      total++; if (bif.abort_mem !== 1'b1) begin bad++; $display("FAIL er_abort got=%0b exp=1", bif.abort_mem); end
      tick();
      total++; if (bif.wb_valid !== 1'b1 || bif.wb_addr !== 8'h04) begin bad++; $display("FAIL er_wb valid=%0b addr=%h exp=1/04", bif.wb_valid, bif.wb_addr); end
      read_line(2'd0, rs, rt);
      total++; if (rs !== SHARED || rt !== 6'h01) begin bad++; $display("FAIL er_line got=%0b/%h exp=10/01", rs, rt); end
      tick();
      total++; if (bif.snoop_done !== 1'b1 || bif.wb_valid !== 1'b0) begin bad++; $display("FAIL er_done done=%0b wb=%0b exp=1/0", bif.snoop_done, bif.wb_valid); end
      tick();
      send(READ_MISS, 8'h08);
      total++; if (bif.abort_mem !== 1'b0) begin bad++; $display("FAIL miss_abort got=%0b exp=0", bif.abort_mem); end
      tick();
      total++; if (bif.snoop_done !== 1'b1 || bif.wb_valid !== 1'b0) begin bad++; $display("FAIL miss_done done=%0b wb=%0b exp=1/0", bif.snoop_done, bif.wb_valid); end
      read_line(2'd0, rs, rt);
      total++; if (rs !== SHARED || rt !== 6'h01) begin bad++; $display("FAIL miss_line got=%0b/%h exp=10/01", rs, rt); end
      bif.wb_ready = 1'b0;
      tick();
   endtask

   task automatic test_invalidate_empty;
      cpu_write(2'd3, 6'h2C, EXCLUSIVE);
      send(INVALIDATE, 8'hB3);
      total++; if (bif.proto_err !== 1'b1 || bif.abort_mem !== 1'b0) begin bad++; $display("FAIL inv_perr perr=%0b abort=%0b exp=1/0", bif.proto_err, bif.abort_mem); end
      tick();
      total++; if (bif.snoop_done !== 1'b1 || bif.wb_valid !== 1'b0 || bif.proto_err !== 1'b0) begin
         bad++; $display("FAIL inv_done done=%0b wb=%0b perr=%0b exp=1/0/0", bif.snoop_done, bif.wb_valid, bif.proto_err);
      end
      read_line(2'd3, rs, rt);
      total++; if (rs !== INVALID) begin bad++; $display("FAIL inv_line got=%0b exp=00", rs); end
      tick();
      send(EMPTY, 8'hB3);
      total++; if (bif.proto_err !== 1'b0 || bif.abort_mem !== 1'b0) begin bad++; $display("FAIL empty_lookup perr=%0b abort=%0b exp=0/0", bif.proto_err, bif.abort_mem); end
      tick();
      total++; if (bif.snoop_done !== 1'b1 || bif.wb_valid !== 1'b0) begin bad++; $display("FAIL empty_done done=%0b wb=%0b exp=1/0", bif.snoop_done, bif.wb_valid); end
      tick();
   endtask

   task automatic test_upd_ignore_and_lookup;
      cpu_write(2'd2, 6'h3F, 2'b11);
      read_line(2'd2, rs, rt);
      total++; if (rs !== INVALID || rt !== 6'h3A) begin bad++; $display("FAIL upd11_line got=%0b/%h exp=00/3a", rs, rt); end
      send(READ_MISS, 8'h00);
      bif.cpu_upd_valid = 1'b1;
      bif.cpu_upd_index = 2'd2;
      bif.cpu_upd_tag   = 6'h11;
      bif.cpu_upd_state = SHARED;
      #1;
      total++; if (bif.cpu_upd_ready !== 1'b0) begin bad++; $display("FAIL lk_upd_ready got=%0b exp=0", bif.cpu_upd_ready); end
      tick();
      total++; if (bif.cpu_upd_ready !== 1'b1) begin bad++; $display("FAIL done_upd_ready got=%0b exp=1", bif.cpu_upd_ready); end
      read_line(2'd2, rs, rt);
      total++; if (rs !== INVALID || rt !== 6'h3A) begin bad++; $display("FAIL lk_upd_blocked got=%0b/%h exp=00/3a", rs, rt); end
      tick();
      bif.cpu_upd_valid = 1'b0;
      read_line(2'd2, rs, rt);
      total++; if (rs !== SHARED || rt !== 6'h11) begin bad++; $display("FAIL lk_upd_late got=%0b/%h exp=10/11", rs, rt); end
   endtask

   task automatic test_reset_mid_wb;
      cpu_write(2'd1, 6'h05, EXCLUSIVE);
      bif.wb_ready = 1'b0;
      send(WRITE_MISS, 8'h15);
      tick();
      total++; if (bif.wb_valid !== 1'b1) begin bad++; $display("FAIL rwb_pre got=%0b exp=1", bif.wb_valid); end
      reset = 1'b1;
      tick();
      total++; if (bif.wb_valid !== 1'b0 || bif.snoop_done !== 1'b0) begin bad++; $display("FAIL rwb_drop wb=%0b done=%0b exp=0/0", bif.wb_valid, bif.snoop_done); end
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         read_line(i[1:0], rs, rt);
         total++; if (rs !== 2'b00) begin bad++; $display("FAIL rwb_line%0d got=%0b exp=00", i, rs); end
      end
      for (int c = 0; c < 3; c++) begin
         tick();
         total++; if (bif.snoop_done !== 1'b0 || bif.wb_valid !== 1'b0) begin bad++; $display("FAIL rwb_quiet%0d done=%0b wb=%0b exp=0/0", c, bif.snoop_done, bif.wb_valid); end
      end
   endtask

   initial begin
      reset             = 1'b1;
      bif.bus_valid     = 1'b0;
      bif.bus_msg       = EMPTY;
      bif.bus_addr      = 8'h00;
      bif.cpu_upd_valid = 1'b0;
      bif.cpu_upd_index = 2'd0;
      bif.cpu_upd_tag   = 6'h00;
      bif.cpu_upd_state = INVALID;
      bif.cpu_rd_index  = 2'd0;
      bif.wb_ready      = 1'b0;
      test_reset();
      test_shared_read();
      test_excl_write_wb();
      test_excl_read();
      test_invalidate_empty();
      test_upd_ignore_and_lookup();
      test_reset_mid_wb();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/snoop_bus_controller.md
Name: snoop_bus_controller

Overview:
- Bus-side (snooping) half of the MSI coherence controller for one private cache.
- Accepts remote messages from the shared bus (read miss, write miss, invalidate) and looks up the matching line in its tag/state array.
- Downgrades or invalidates the line, and issues a block write-back plus a memory-abort when the line holds the only (exclusive/modified) copy.
- The CPU-side state machine writes line state/tag through a separate update port.

Parameters:
ADDR_W, 8, block address width on bus
IDX_W, 2, index bits; LINES = 2**IDX_W direct-mapped lines; tag = ADDR_W-IDX_W bits

Ports:
clock  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-high
bus_valid  in  1  remote message present
bus_msg  in  2  00 read miss, 01 write miss, 10 invalidate, 11 empty
bus_addr  in  ADDR_W  block address of message
bus_ready  out  1  controller can accept message
cpu_upd_valid  in  1  CPU-side line update request
cpu_upd_index  in  IDX_W  line to update
cpu_upd_tag  in  ADDR_W-IDX_W  new tag
cpu_upd_state  in  2  new state: 00 invalid, 01 exclusive, 10 shared
cpu_upd_ready  out  1  update accepted when valid&ready
cpu_rd_index  in  IDX_W  combinational lookup index
cpu_rd_state  out  2  state of cpu_rd_index line
cpu_rd_tag  out  ADDR_W-IDX_W  tag of cpu_rd_index line
wb_valid  out  1  write-back request to memory
wb_addr  out  ADDR_W  block address being written back
wb_ready  in  1  memory accepts write-back
abort_mem  out  1  one-cycle pulse: memory must not answer this miss
snoop_done  out  1  one-cycle pulse: message fully handled
proto_err  out  1  one-cycle pulse: invalidate hit an exclusive line

Behaviour:
- Reset (synchronous, active-high): all lines invalid, tags 0, FSM IDLE; wb_valid, abort_mem, snoop_done, proto_err = 0; bus_ready = 0 and cpu_upd_ready = 0 while reset is high.
- FSM states: IDLE, LOOKUP, WRITEBACK, DONE.
- Control outputs:
  - bus_ready = (state==IDLE).
  - cpu_upd_ready = (state!=LOOKUP), so CPU and bus never write the array in the same cycle.
- IDLE: on bus_valid&bus_ready, register bus_msg and bus_addr, then go to LOOKUP.
- LOOKUP (exactly 1 cycle):
  - idx = addr[IDX_W-1:0], tag = addr[ADDR_W-1:IDX_W].
  - hit = line state != invalid and stored tag == tag.
  - Line state is committed at the end of this cycle:
    - miss or msg 11: no change -> DONE.
    - shared hit, read miss: stays shared -> DONE.
    - shared hit, write miss or invalidate: -> invalid -> DONE.
    - exclusive hit, read miss: -> shared; abort_mem pulses this cycle -> WRITEBACK.
    - exclusive hit, write miss: -> invalid; abort_mem pulses this cycle -> WRITEBACK.
    - exclusive hit, invalidate: -> invalid; proto_err pulses; no write-back -> DONE.
- WRITEBACK:
  - wb_valid = 1 with wb_addr = registered address, held stable until wb_ready.
  - On wb_valid&wb_ready -> DONE. wb_valid drops the following cycle.
- DONE: snoop_done = 1 for one cycle -> IDLE.
- Latency from accept cycle T:
  - snoop_done at T+2 without write-back.
  - With write-back, snoop_done one cycle after the wb handshake; earliest is T+3 when wb_ready is already high.
- CPU update: when cpu_upd_valid&cpu_upd_ready, write state and tag at cpu_upd_index on that edge. cpu_upd_state 11 is ignored (no write).
- CPU update in DONE/WRITEBACK to the line just snooped is allowed; it overwrites the bus result.
- cpu_rd_state/cpu_rd_tag are purely combinational from the array and reflect updates the cycle after the write edge.
- bus_valid outside IDLE is ignored; the master must hold it until bus_ready.
- Reset mid-WRITEBACK: wb_valid low from the next cycle; no snoop_done; array cleared.

Decomposition:
- Shared package msi_pkg holds:
  - line states INVALID=2'b00, EXCLUSIVE=2'b01, SHARED=2'b10;
  - bus messages READ_MISS=2'b00, WRITE_MISS=2'b01, INVALIDATE=2'b10, EMPTY=2'b11;
  - the FSM state typedef.
- Sub-module snoop_line_array: tag+state storage with one combinational read port, one lookup read port and one write port muxed between bus commit and CPU update (never simultaneous).

Test Plan:
- Reset, then read cpu_rd_state for every index -> all 00; bus_ready=1 the first cycle after reset drops.
- CPU sets idx1 tag 0x05 shared; bus read miss addr 0x15 -> line stays 10; snoop_done at T+2; no wb_valid, no abort_mem.
- CPU sets idx2 tag 0x3A exclusive; bus write miss addr 0xEA, wb_ready held low 3 cycles -> abort_mem pulse at T+1; line 00; wb_valid with wb_addr=0xEA held 3 cycles; snoop_done the cycle after the handshake.
- Exclusive idx0 tag 0x01; bus read miss 0x04 -> line 10, abort_mem, write-back to 0x04. Repeat with addr 0x08 (tag mismatch) -> no change, no wb_valid.
- Exclusive idx3; bus invalidate to its address -> proto_err pulse, line 00, no wb_valid. Then msg 11 -> only snoop_done.
- Assert reset during WRITEBACK -> wb_valid=0 next cycle, all lines 00, no snoop_done. Also check a CPU update attempted in LOOKUP sees cpu_upd_ready=0 and lands one cycle later.
